// File: rtl/poly_song_reader_pkg.sv
// poly_song_reader_pkg: song word layout, FSM state encodings and voice-pointer sizing shared by RTL, ROM tooling and bench
package poly_song_reader_pkg;
  localparam int DEF_NOTE_W = 6;
  localparam int DEF_DUR_W = 6;
  localparam int DEF_META_W = 3;
  localparam int DEF_WORD_W = 1 + DEF_NOTE_W + DEF_DUR_W + DEF_META_W;
  localparam int META_LSB = 0;
  localparam int DUR_LSB = META_LSB + DEF_META_W;
  localparam int NOTE_LSB = DUR_LSB + DEF_DUR_W;
  localparam int KIND_BIT = NOTE_LSB + DEF_NOTE_W;
  localparam logic [DEF_WORD_W-1:0] END_MARKER = '0;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FETCH = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;
  function automatic int ptr_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/poly_song_reader_voice_allocator.sv
// poly_song_reader_voice_allocator: picks the first idle voice at or after rr_ptr, stealing rr_ptr when all are busy
module poly_song_reader_voice_allocator
  import poly_song_reader_pkg::*;
#(
  parameter int NUM_VOICES = 3
) (
  input logic [ptr_w(NUM_VOICES)-1:0] i_rr_ptr,
  input logic [NUM_VOICES-1:0] i_busy,
  output logic [NUM_VOICES-1:0] o_sel,
  output logic [ptr_w(NUM_VOICES)-1:0] o_idx
);
  localparam int PW = ptr_w(NUM_VOICES);
  // scan downward so the candidate closest to rr_ptr is written last and wins
  always_comb begin
    o_idx = i_rr_ptr;
    for (int k = NUM_VOICES - 1; k >= 0; k--)
      if (!i_busy[PW'((int'(i_rr_ptr) + k) % NUM_VOICES)]) o_idx = PW'((int'(i_rr_ptr) + k) % NUM_VOICES);
  end
  assign o_sel = NUM_VOICES'(1) << o_idx;
endmodule

// File: rtl/poly_song_reader.sv
// poly_song_reader: walks a song ROM and dispatches note and wait entries to NUM_VOICES note players
module poly_song_reader
  import poly_song_reader_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SONG_BITS = 2,
  parameter int ENTRY_BITS = 5,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W = DEF_DUR_W,
  parameter int META_W = DEF_META_W,
  localparam int WORD_W = 1 + NOTE_W + DUR_W + META_W
) (
  input logic clk,
  input logic reset,
  input logic play,
  input logic [SONG_BITS-1:0] song,
  input logic beat,
  input logic [NUM_VOICES-1:0] voice_busy,
  output logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr,
  input logic [WORD_W-1:0] rom_data,
  output logic [NUM_VOICES-1:0] new_note,
  output logic [NUM_VOICES*NOTE_W-1:0] note,
  output logic [NUM_VOICES*DUR_W-1:0] duration,
  output logic [NUM_VOICES*META_W-1:0] metadata,
  output logic song_done
);
  localparam int PW = ptr_w(NUM_VOICES);
  state_t r_state;
  logic [SONG_BITS-1:0] r_song;
  logic [ENTRY_BITS-1:0] r_ptr;
  logic [PW-1:0] r_rr;
  logic [DUR_W-1:0] r_cnt;
  logic r_rearm;
  logic [PW-1:0] w_idx, w_next_rr;
  logic [NUM_VOICES-1:0] w_sel;
  logic w_kind, w_end, w_abort, w_adv, w_last;
  logic [NOTE_W-1:0] w_note;
  logic [DUR_W-1:0] w_dur;
  logic [META_W-1:0] w_meta;
  poly_song_reader_voice_allocator #(.NUM_VOICES(NUM_VOICES)) u_alloc (
    .i_rr_ptr(r_rr),
    .i_busy(voice_busy),
    .o_sel(w_sel),
    .o_idx(w_idx)
  );
  assign w_kind = rom_data[WORD_W-1];
  assign w_note = rom_data[META_W+DUR_W +: NOTE_W];
  assign w_dur = rom_data[META_W +: DUR_W];
  assign w_meta = rom_data[META_W-1:0];
  assign w_end = rom_data == WORD_W'(END_MARKER);
  assign w_last = &r_ptr;
  assign w_abort = (r_state inside {S_FETCH, S_DECODE, S_WAIT}) && (song != r_song);
  assign w_adv = (r_state == S_DECODE && !w_end && (!w_kind || w_dur == '0)) ||
                 (r_state == S_WAIT && beat && r_cnt == DUR_W'(1));
  assign w_next_rr = (int'(w_idx) == NUM_VOICES - 1) ? '0 : w_idx + 1'b1;
  // IDLE follows the live select so the first fetch address is visible before start
  assign rom_addr = {r_state == S_IDLE ? song : r_song, r_ptr};
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_song <= '0;
      r_ptr <= '0;
      r_rr <= '0;
      r_cnt <= '0;
      r_rearm <= 1'b0;
      new_note <= '0;
      note <= '0;
      duration <= '0;
      metadata <= '0;
      song_done <= 1'b0;
    end else begin
      new_note <= '0;
      song_done <= 1'b0;
      if (!play || song != r_song) r_rearm <= 1'b0;
      if (w_abort) begin
        r_song <= song;
        r_ptr <= '0;
        r_cnt <= '0;
        r_state <= S_FETCH;
      end else if (r_state == S_DONE) begin
        r_ptr <= '0;
        r_rearm <= 1'b1;
        r_state <= S_IDLE;
      end else if (play) begin
        case (r_state)
          S_IDLE: if (!r_rearm) begin
            r_song <= song;
            r_state <= S_FETCH;
          end
          S_FETCH: r_state <= S_DECODE;
          S_DECODE: if (w_end) begin
            r_state <= S_DONE;
            song_done <= 1'b1;
          end else if (!w_kind) begin
            new_note <= w_sel;
            r_rr <= w_next_rr;
            for (int v = 0; v < NUM_VOICES; v++)
              if (w_sel[v]) begin
                note[v*NOTE_W +: NOTE_W] <= w_note;
                duration[v*DUR_W +: DUR_W] <= w_dur;
                metadata[v*META_W +: META_W] <= w_meta;
              end
          end else if (w_dur != '0) begin
            r_cnt <= w_dur;
            r_state <= S_WAIT;
          end
          S_WAIT: if (beat) r_cnt <= r_cnt - 1'b1;
          default: r_state <= S_IDLE;
        endcase
        if (w_adv) begin
          r_ptr <= r_ptr + 1'b1;
          r_state <= w_last ? S_DONE : S_FETCH;
          song_done <= w_last;
        end
      end
    end
  end
endmodule

// File: tb/tb_poly_song_reader.sv
// tb_poly_song_reader: directed and randomized scenarios against an event-level model of the song reader
module tb_poly_song_reader;
  import poly_song_reader_pkg::*;
  localparam int NV = 3, SB = 2, EB = 5, NW = 6, DW = 6, MW = 3, WW = 16, AW = SB + EB;
  logic clk = 1'b0, reset = 1'b0, play = 1'b0, beat = 1'b0;
  logic [SB-1:0] song = '0;
  logic [NV-1:0] voice_busy = '0;
  logic [AW-1:0] rom_addr;
  logic [WW-1:0] rom_data = '0;
  logic [NV-1:0] new_note;
  logic [NV*NW-1:0] note;
  logic [NV*DW-1:0] duration;
  logic [NV*MW-1:0] metadata;
  logic song_done;
  logic [WW-1:0] rom [0:(1<<AW)-1];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  poly_song_reader #(.NUM_VOICES(NV), .SONG_BITS(SB), .ENTRY_BITS(EB), .NOTE_W(NW), .DUR_W(DW), .META_W(MW)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .beat(beat), .voice_busy(voice_busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .new_note(new_note), .note(note),
    .duration(duration), .metadata(metadata), .song_done(song_done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [WW-1:0] mk_note(int n, int d, int m);
    logic [WW-1:0] w;
    w = '0;
    w[NOTE_LSB +: NW] = NW'(n);
    w[DUR_LSB +: DW] = DW'(d);
    w[META_LSB +: MW] = MW'(m);
    return w;
  endfunction

  function automatic logic [WW-1:0] mk_wait(int d);
    logic [WW-1:0] w;
    w = '0;
    w[KIND_BIT] = 1'b1;
    w[DUR_LSB +: DW] = DW'(d);
    return w;
  endfunction

  function automatic logic [AW-1:0] addr(int s, int e);
    return AW'((s << EB) | e);
  endfunction

  // allocation rule: first idle voice from rr upward, otherwise steal rr
  function automatic int alloc(int rr, logic [NV-1:0] busy);
    for (int k = 0; k < NV; k++) if (!busy[(rr + k) % NV]) return (rr + k) % NV;
    return rr;
  endfunction

  function automatic logic [WW-1:0] slot(int v);
    return {1'b0, note[v*NW +: NW], duration[v*DW +: DW], metadata[v*MW +: MW]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; play = 1'b0; beat = 1'b0; voice_busy = '0; song = '0;
    for (int a = 0; a < (1 << AW); a++) rom[a] = END_MARKER;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic pulse_beat;
    beat = 1'b1;
    tick;
    beat = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (new_note !== '0 || song_done !== 1'b0) begin failures++; $display("FAIL reset_pulses got nn=%b sd=%b exp 0", new_note, song_done); end
    checks++; if (note !== '0 || duration !== '0 || metadata !== '0) begin failures++; $display("FAIL reset_slices got %h/%h/%h exp 0", note, duration, metadata); end
    checks++; if (rom_addr !== addr(0, 0)) begin failures++; $display("FAIL reset_addr got=%h exp=%h", rom_addr, addr(0, 0)); end
    song = 2'd3;
    #1;
    checks++; if (rom_addr !== addr(3, 0)) begin failures++; $display("FAIL idle_addr_follows_song got=%h exp=%h", rom_addr, addr(3, 0)); end
  endtask

  task automatic test_basic;
    int sd = 0, nn = 0, found = 0;
    do_reset;
    rom[addr(1, 0)] = mk_note(20, 4, 1);
    rom[addr(1, 1)] = mk_note(22, 4, 2);
    rom[addr(1, 2)] = mk_wait(2);
    song = 2'd1; play = 1'b1;
    tick; tick; tick;
    checks++; if (new_note !== 3'b001 || note[0 +: NW] !== 6'd20) begin failures++; $display("FAIL basic_first_note got nn=%b n=%0d exp nn=001 n=20", new_note, note[0 +: NW]); end
    tick;
    checks++; if (new_note !== 3'b000) begin failures++; $display("FAIL basic_gap got=%b exp=000", new_note); end
    tick;
    checks++; if (new_note !== 3'b010 || note[NW +: NW] !== 6'd22 || note[0 +: NW] !== 6'd20) begin failures++; $display("FAIL basic_second_note got nn=%b n=%h exp nn=010 n1=22 n0=20", new_note, note); end
    tick; tick; tick; tick;
    pulse_beat;
    tick; tick;
    checks++; if (rom_addr !== addr(1, 2)) begin failures++; $display("FAIL basic_wait_hold got=%h exp=%h", rom_addr, addr(1, 2)); end
    pulse_beat;
    checks++; if (rom_addr !== addr(1, 3)) begin failures++; $display("FAIL basic_wait_release got=%h exp=%h", rom_addr, addr(1, 3)); end
    for (int c = 0; c < 20; c++) begin
      tick;
      sd += int'(song_done);
      nn += int'(new_note != '0);
    end
    checks++; if (sd != 1 || nn != 0) begin failures++; $display("FAIL basic_done_once got sd=%0d nn=%0d exp sd=1 nn=0", sd, nn); end
    play = 1'b0;
    tick;
    play = 1'b1;
    for (int c = 0; c < 10 && found == 0; c++) begin
      tick;
      if (new_note != '0) found = 1;
    end
    checks++; if (found == 0 || new_note !== 3'b100 || note[2*NW +: NW] !== 6'd20) begin failures++; $display("FAIL basic_restart got found=%0d nn=%b exp nn=100 n2=20", found, new_note); end
  endtask

  task automatic test_alloc;
    logic [WW-1:0] q[$];
    logic [WW-1:0] w;
    logic [NV-1:0] prev;
    int rr = 0, seen = 0, sd = 0, bad = 0, ev;
    do_reset;
    for (int i = 0; i < 24; i++) begin
      w = mk_note(int'($urandom_range(1, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
      rom[addr(2, i)] = w;
      q.push_back(w);
    end
    song = 2'd2; play = 1'b1;
    for (int c = 0; c < 300 && sd == 0; c++) begin
      voice_busy = seen == 0 ? 3'b011 : seen == 1 ? 3'b111 : NV'($urandom);
      prev = voice_busy;
      tick;
      if (song_done) sd++;
      if (new_note != '0) begin
        ev = alloc(rr, prev);
        if (seen == 0 && ev != 2) bad++;
        if (seen == 1 && ev != 0) bad++;
        checks++; if (new_note !== NV'(1 << ev)) begin failures++; $display("FAIL alloc_voice#%0d got=%b exp voice %0d busy=%b", seen, new_note, ev, prev); end
        checks++; if (q.size() == 0 || slot(ev) !== q[0]) begin failures++; $display("FAIL alloc_fields#%0d got=%h exp=%h", seen, slot(ev), q.size() ? q[0] : 16'hxxxx); end
        if (q.size() != 0) void'(q.pop_front());
        rr = (ev + 1) % NV;
        seen++;
      end
    end
    checks++; if (seen != 24 || sd != 1 || bad != 0) begin failures++; $display("FAIL alloc_totals got notes=%0d done=%0d model=%0d exp 24/1/0", seen, sd, bad); end
  endtask

  task automatic test_pause;
    int nn = 0;
    do_reset;
    rom[addr(0, 0)] = mk_wait(3);
    rom[addr(0, 1)] = mk_note(30, 5, 3);
    play = 1'b1;
    tick; tick; tick;
    play = 1'b0;
    for (int b = 0; b < 5; b++) begin
      pulse_beat;
      tick;
    end
    play = 1'b1;
    tick;
    pulse_beat;
    tick;
    pulse_beat;
    checks++; if (rom_addr !== addr(0, 0)) begin failures++; $display("FAIL pause_frozen got=%h exp=%h", rom_addr, addr(0, 0)); end
    tick;
    pulse_beat;
    checks++; if (rom_addr !== addr(0, 1)) begin failures++; $display("FAIL pause_third_beat got=%h exp=%h", rom_addr, addr(0, 1)); end
    tick;
    play = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      nn += int'(new_note != '0);
    end
    checks++; if (nn != 0) begin failures++; $display("FAIL pause_suppress got=%0d pulses exp=0", nn); end
    play = 1'b1;
    tick;
    checks++; if (new_note !== 3'b001 || note[0 +: NW] !== 6'd30) begin failures++; $display("FAIL pause_resume_note got nn=%b n=%0d exp nn=001 n=30", new_note, note[0 +: NW]); end
  endtask

  task automatic test_song_change;
    int sd = 0;
    do_reset;
    rom[addr(0, 0)] = mk_wait(2);
    rom[addr(0, 1)] = mk_note(11, 1, 1);
    rom[addr(2, 0)] = mk_note(40, 9, 6);
    play = 1'b1;
    tick; tick; tick;
    pulse_beat;
    song = 2'd2;
    pulse_beat;
    sd += int'(song_done);
    checks++; if (rom_addr !== addr(2, 0)) begin failures++; $display("FAIL change_addr got=%h exp=%h", rom_addr, addr(2, 0)); end
    tick;
    sd += int'(song_done);
    tick;
    sd += int'(song_done);
    checks++; if (new_note !== 3'b001 || slot(0) !== mk_note(40, 9, 6) || sd != 0) begin failures++; $display("FAIL change_new_song got nn=%b s0=%h sd=%0d exp nn=001 s0=%h sd=0", new_note, slot(0), sd, mk_note(40, 9, 6)); end
  endtask

  task automatic test_full;
    logic [WW-1:0] q[$];
    logic [WW-1:0] w;
    int rr = 0, seen = 0, sd = 0, e = 0, bad_addr = 0, bad_note = 0, late = 0, ev;
    do_reset;
    for (int i = 0; i < 32; i++) begin
      w = mk_note(int'($urandom_range(1, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
      rom[addr(3, i)] = w;
      q.push_back(w);
    end
    song = 2'd3; play = 1'b1;
    for (int c = 0; c < 300 && sd == 0; c++) begin
      tick;
      if (new_note != '0) begin
        ev = alloc(rr, '0);
        if (new_note !== NV'(1 << ev) || q.size() == 0 || slot(ev) !== q[0]) bad_note++;
        if (q.size() != 0) void'(q.pop_front());
        rr = (ev + 1) % NV;
        seen++;
      end
      if (song_done) sd++;
      else if (rom_addr == addr(3, e + 1)) e++;
      else if (rom_addr != addr(3, e)) bad_addr++;
    end
    checks++; if (seen != 32 || bad_note != 0) begin failures++; $display("FAIL full_notes got notes=%0d bad=%0d exp 32/0", seen, bad_note); end
    checks++; if (e != 31 || bad_addr != 0 || sd != 1) begin failures++; $display("FAIL full_addr_seq got last=%0d bad=%0d done=%0d exp 31/0/1", e, bad_addr, sd); end
    for (int c = 0; c < 40; c++) begin
      tick;
      late += int'(new_note != '0) + int'(song_done);
    end
    checks++; if (late != 0) begin failures++; $display("FAIL full_no_wrap got=%0d events exp=0", late); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    rom[addr(0, 0)] = mk_note(33, 7, 5);
    rom[addr(0, 1)] = mk_wait(10);
    play = 1'b1;
    for (int c = 0; c < 6; c++) tick;
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    tick;
    checks++; if (rom_addr !== addr(0, 1) || slot(0) !== mk_note(33, 7, 5)) begin failures++; $display("FAIL async_glitch got addr=%h s0=%h exp addr=%h s0=%h", rom_addr, slot(0), addr(0, 1), mk_note(33, 7, 5)); end
    reset = 1'b0;
    tick;
    checks++; if (new_note !== '0 || note !== '0 || duration !== '0 || metadata !== '0 || song_done !== 1'b0 || rom_addr !== addr(0, 0)) begin failures++; $display("FAIL mid_reset got nn=%b n=%h d=%h m=%h sd=%b a=%h exp all 0", new_note, note, duration, metadata, song_done, rom_addr); end
    play = 1'b0;
    song = 2'd2;
    reset = 1'b1;
    tick;
    checks++; if (rom_addr !== addr(2, 0) || new_note !== '0) begin failures++; $display("FAIL mid_reset_idle got addr=%h nn=%b exp addr=%h nn=0", rom_addr, new_note, addr(2, 0)); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_alloc;
    test_pause;
    test_song_change;
    test_full;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/poly_song_reader.md
Name: poly_song_reader

Overview:
- Parametrised successor to the single-voice song reader: steps through one of 2^SONG_BITS songs in an external synchronous song ROM and dispatches note events to NUM_VOICES note players.
- Adds explicit wait entries (beat-timed gaps), voice allocation, pause and restart on song change.
- Sits between the top-level controls (play, song select, beat generator) and the per-voice note players.

Parameters:
- NUM_VOICES, 3, number of note-player channels (1..8)
- SONG_BITS, 2, song select width; songs = 2^SONG_BITS
- ENTRY_BITS, 5, entries per song = 2^ENTRY_BITS
- NOTE_W, 6, note field width
- DUR_W, 6, duration field width (beats)
- META_W, 3, metadata field width
- WORD_W, 1+NOTE_W+DUR_W+META_W (16), ROM word width; derived, not overridable

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- play  in  1  level: 1 = run, 0 = pause
- song  in  SONG_BITS  song select
- beat  in  1  one-cycle beat pulse
- voice_busy  in  NUM_VOICES  bit v high while voice v is still sounding
- rom_addr  out  SONG_BITS+ENTRY_BITS  {song_latched, entry_ptr}
- rom_data  in  WORD_W  ROM word, valid 1 cycle after rom_addr
- new_note  out  NUM_VOICES  one-cycle load pulse per voice
- note  out  NUM_VOICES*NOTE_W  per-voice note, voice v at [v*NOTE_W +: NOTE_W]
- duration  out  NUM_VOICES*DUR_W  per-voice duration
- metadata  out  NUM_VOICES*META_W  per-voice metadata
- song_done  out  1  one-cycle pulse at end of song

Behaviour:
- ROM word format is {kind[WORD_W-1], note, duration, metadata}.
  - kind=0: note event.
  - kind=1: wait of `duration` beats.
  - All-zero word: end marker.
- States: IDLE, FETCH, DECODE, WAIT, DONE.
- Reset (reset=0 at clk edge): state IDLE, entry_ptr 0, rr_ptr 0, wait counter 0. All outputs 0 except rom_addr = {song, 0}.
- IDLE: when play=1, latch song and go to FETCH. Otherwise stay.
- FETCH: drive rom_addr for one cycle, then go to DECODE. ROM latency is exactly 1 cycle.
- DECODE:
  - End marker -> DONE.
  - Note event:
    - Choose the voice: the first non-busy voice scanning from rr_ptr upward, modulo NUM_VOICES. If all voices are busy, choose rr_ptr (steal).
    - Register note/duration/metadata into that voice's output slice and pulse new_note[v] in the same cycle the slice updates.
    - Set rr_ptr to v+1 mod NUM_VOICES.
    - Advance entry_ptr and go to FETCH.
  - Wait with duration 0: advance entry_ptr and go to FETCH.
  - Wait with duration d>0: load counter = d and go to WAIT.
- Note-to-note issue rate is 1 per 2 cycles.
- WAIT:
  - Decrement the counter on each beat seen while in WAIT. A beat in the DECODE cycle is ignored.
  - On the beat that takes the counter 1->0: advance entry_ptr and go to FETCH on the next cycle.
- Last entry: if entry_ptr = 2^ENTRY_BITS-1 has been processed (including its wait) and is not an end marker, go to DONE instead of wrapping.
- DONE:
  - Pulse song_done for exactly 1 cycle.
  - Clear entry_ptr, go to IDLE, and set the rearm flag.
  - While rearm is set, IDLE does not start a new song. Rearm clears when play=0 or song differs from song_latched.
- Pause: play=0 in FETCH, DECODE or WAIT freezes state, counter and entry_ptr.
  - A pending ROM read completes: DECODE is re-evaluated after resume.
  - Beats are ignored while paused.
  - new_note pulses are suppressed while paused.
- Song change: song differing from song_latched while not IDLE/DONE aborts the current song.
  - Next state FETCH with entry_ptr 0 and the new song latched.
  - No song_done pulse.
  - Voice outputs are kept.
  - The abort takes priority over a same-cycle beat, note issue or end marker.
- Voice outputs hold their values until that voice is next loaded.
- Reset mid-song: everything returns to reset values on the next edge.

Decomposition:
- Shared package, used by the song ROM generator and testbench:
  - word-field position constants: KIND_BIT, NOTE_LSB, DUR_LSB, META_LSB
  - end-marker constant
  - state encodings (3-bit)
- One sub-module, voice_allocator: combinational, with rr_ptr, voice_busy -> one-hot select. Parametrised by NUM_VOICES.

Test Plan:
- Song 1 = [note 20/dur 4, note 22/dur 4, wait 2, END], play=1, busy=0:
  - new_note = 001 with note slice0 = 20.
  - Two cycles later, new_note = 010 with slice1 = 22.
  - FETCH resumes after exactly 2 beats; song_done pulses once.
  - No restart until play toggles.
- voice_busy = 011 with rr_ptr = 0 -> next note lands on voice 2. voice_busy = 111 -> steals voice at rr_ptr.
- play=0 for 5 beats in the middle of a wait 3 -> counter frozen. After resume, 3 more beats are needed before the next fetch.
- Song changes 0->2 during WAIT -> next rom_addr = {2,0}, no song_done. A simultaneous beat is ignored.
- 32 note entries with no end marker -> rom_addr runs 0..31, song_done after entry 31, no wrap to entry 0.
- reset=0 asserted during WAIT -> next cycle all outputs 0, state IDLE. An asynchronous reset pulse between edges has no effect.
